// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
// Walks one convolution layer pass (kernel, output row/col, kernel row/col)
// and issues image/weight RAM reads plus MAC accumulator control.
// Optional cycle counter: define CONV_SEQ_PERF_EN to enable perf_cycles;
// otherwise perf_cycles is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validate latched config
// CALC  | compute output edge length O by repeated subtraction
// RUN   | one tap issued per non-stalled cycle
// DRAIN | flush the final tap into the accumulator stage
// FIN   | one-cycle done pulse
module conv_window_sequencer #(
  parameter int IMG_ADDR_W = 10,
  parameter int W_ADDR_W   = 10,
  parameter int OUT_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            kernel_size,
  input  logic [4:0]            img_size,
  input  logic [1:0]            stride,
  input  logic [4:0]            number_kernel,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  rd_en,
  output logic [IMG_ADDR_W-1:0] img_addr,
  output logic [W_ADDR_W-1:0]   w_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  acc_last,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [15:0]           perf_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CALC  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [2:0] k_size;
  logic [4:0] s_size;
  logic [1:0] stride_q;
  logic [4:0] n_kern;
  logic [4:0] rem;
  logic [5:0] o_cnt;
  logic [4:0] k_idx;
  logic [5:0] oy, ox;
  logic [2:0] ky, kx;

  logic freeze, cfg_bad, calc_step, issue;
  logic last_kx, last_ky, last_ox, last_oy, last_k, last_tap;

  logic [31:0] img_full, w_full, out_full;

  logic                  rd_q, first_q, last_q;
  logic [IMG_ADDR_W-1:0] img_addr_q;
  logic [W_ADDR_W-1:0]   w_addr_q;
  logic [OUT_ADDR_W-1:0] out_pre_q;
  logic                  acc_en_q, acc_clr_q, acc_last_q;
  logic [OUT_ADDR_W-1:0] out_addr_q;

  // stall only freezes the states that walk or flush the pass
  always_comb begin
    freeze    = stall && ((state == CALC) || (state == RUN) || (state == DRAIN));
    issue     = (state == RUN) && !stall;
    cfg_bad   = (k_size == 3'd0) || (stride_q == 2'd0) || (n_kern == 5'd0) ||
                ({2'b00, k_size} > s_size);
    calc_step = (rem >= {3'b000, stride_q});
    last_kx   = (kx == k_size - 3'd1);
    last_ky   = (ky == k_size - 3'd1);
    last_ox   = (ox == o_cnt - 6'd1);
    last_oy   = (oy == o_cnt - 6'd1);
    last_k    = (k_idx == n_kern - 5'd1);
    last_tap  = last_k && last_oy && last_ox && last_ky && last_kx;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = cfg_bad ? FIN : CALC;
      CALC:    if (!stall && !calc_step) state_nxt = RUN;
      RUN:     if (issue && last_tap) state_nxt = DRAIN;
      DRAIN:   if (!stall) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // latch config on accepted start; sticky config error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_size   <= '0;
      s_size   <= '0;
      stride_q <= '0;
      n_kern   <= '0;
      cfg_err  <= 1'b0;
    end else if (state == IDLE && start) begin
      k_size   <= kernel_size;
      s_size   <= img_size;
      stride_q <= stride;
      n_kern   <= number_kernel;
      cfg_err  <= 1'b0;
    end else if (state == CHECK && cfg_bad) begin
      cfg_err  <= 1'b1;
    end
  end

  // output edge length: O = floor((S-K)/stride)+1 by repeated subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      o_cnt <= '0;
    end else if (state == CHECK && !cfg_bad) begin
      rem   <= s_size - {2'b00, k_size};
      o_cnt <= 6'd1;
    end else if (state == CALC && !stall && calc_step) begin
      rem   <= rem - {3'b000, stride_q};
      o_cnt <= o_cnt + 6'd1;
    end
  end

  // tap counters, kx innermost, kernel index outermost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_idx <= '0;
      oy    <= '0;
      ox    <= '0;
      ky    <= '0;
      kx    <= '0;
    end else if (state == CHECK) begin
      k_idx <= '0;
      oy    <= '0;
      ox    <= '0;
      ky    <= '0;
      kx    <= '0;
    end else if (issue) begin
      if (!last_kx) kx <= kx + 3'd1;
      else begin
        kx <= '0;
        if (!last_ky) ky <= ky + 3'd1;
        else begin
          ky <= '0;
          if (!last_ox) ox <= ox + 6'd1;
          else begin
            ox <= '0;
            if (!last_oy) oy <= oy + 6'd1;
            else begin
              oy    <= '0;
              k_idx <= last_k ? 5'd0 : k_idx + 5'd1;
            end
          end
        end
      end
    end
  end

  // address arithmetic from the current counters, truncated to port width
  always_comb begin
    img_full = (32'(oy) * 32'(stride_q) + 32'(ky)) * 32'(s_size) +
               32'(ox) * 32'(stride_q) + 32'(kx);
    w_full   = 32'(k_idx) * 32'(k_size) * 32'(k_size) + 32'(ky) * 32'(k_size) + 32'(kx);
    out_full = 32'(k_idx) * 32'(o_cnt) * 32'(o_cnt) + 32'(oy) * 32'(o_cnt) + 32'(ox);
  end

  // read stage: registers the tap being issued; addresses hold between passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      img_addr_q <= '0;
      w_addr_q   <= '0;
      out_pre_q  <= '0;
    end else if (!freeze) begin
      rd_q <= issue;
      if (issue) begin
        first_q    <= (ky == 3'd0) && (kx == 3'd0);
        last_q     <= last_ky && last_kx;
        img_addr_q <= img_full[IMG_ADDR_W-1:0];
        w_addr_q   <= w_full[W_ADDR_W-1:0];
        out_pre_q  <= out_full[OUT_ADDR_W-1:0];
      end
    end
  end

  // accumulate stage: one cycle behind the read stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      out_addr_q <= '0;
    end else if (!freeze) begin
      acc_en_q   <= rd_q;
      acc_clr_q  <= rd_q && first_q;
      acc_last_q <= rd_q && last_q;
      if (rd_q) out_addr_q <= out_pre_q;
    end
  end

  // strobes are masked while frozen so a held tap issues exactly once
  always_comb begin
    rd_en    = rd_q && !freeze;
    acc_en   = acc_en_q && !freeze;
    img_addr = img_addr_q;
    w_addr   = w_addr_q;
    acc_clr  = acc_clr_q;
    acc_last = acc_last_q;
    out_addr = out_addr_q;
  end

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] perf_q;

  // active-cycle counter, stalls included, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state == IDLE && start) begin
      perf_q <= '0;
    end else if ((state == CALC || state == RUN || state == DRAIN) && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: a loop-level reference model
// pushes expected reads, accumulator events and completions; a monitor pops
// and compares whenever the DUT strobes rd_en, acc_en or done.
module tb_conv_window_sequencer;
  localparam int IMG_ADDR_W = 10;
  localparam int W_ADDR_W   = 10;
  localparam int OUT_ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [2:0] kernel_size = '0;
  logic [4:0] img_size = '0;
  logic [1:0] stride = '0;
  logic [4:0] number_kernel = '0;
  logic busy, done, cfg_err, rd_en, acc_clr, acc_en, acc_last;
  logic [IMG_ADDR_W-1:0] img_addr;
  logic [W_ADDR_W-1:0]   w_addr;
  logic [OUT_ADDR_W-1:0] out_addr;
  logic [15:0] perf_cycles;

  conv_window_sequencer #(
    .IMG_ADDR_W(IMG_ADDR_W), .W_ADDR_W(W_ADDR_W), .OUT_ADDR_W(OUT_ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_size(kernel_size),
    .img_size(img_size), .stride(stride), .number_kernel(number_kernel),
    .stall(stall), .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .img_addr(img_addr), .w_addr(w_addr), .acc_clr(acc_clr),
    .acc_en(acc_en), .acc_last(acc_last), .out_addr(out_addr),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] img; logic [31:0] w; } rd_t;
  typedef struct packed { logic clr; logic last; logic [31:0] oaddr; } acc_t;
  typedef struct packed { logic err; logic [31:0] taps; } done_t;

  rd_t   rd_exp[$];
  acc_t  acc_exp[$];
  done_t done_exp[$];

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // reference model: enumerate every tap of the pass from the layer rules
  task automatic push_pass(input int kk, input int ss, input int st, input int nn);
    rd_t r;
    acc_t a;
    done_t d;
    int o;
    if (kk == 0 || st == 0 || nn == 0 || kk > ss) begin
      d.err = 1'b1; d.taps = 0;
      done_exp.push_back(d);
      return;
    end
    o = (ss - kk) / st + 1;
    for (int k = 0; k < nn; k++)
      for (int oy = 0; oy < o; oy++)
        for (int ox = 0; ox < o; ox++)
          for (int ky = 0; ky < kk; ky++)
            for (int kx = 0; kx < kk; kx++) begin
              r.img = 32'(((oy * st + ky) * ss + ox * st + kx) % (1 << IMG_ADDR_W));
              r.w   = 32'((k * kk * kk + ky * kk + kx) % (1 << W_ADDR_W));
              rd_exp.push_back(r);
              a.clr   = (ky == 0 && kx == 0);
              a.last  = (ky == kk - 1 && kx == kk - 1);
              a.oaddr = 32'((k * o * o + oy * o + ox) % (1 << OUT_ADDR_W));
              acc_exp.push_back(a);
            end
    d.err = 1'b0; d.taps = 32'(nn * o * o * kk * kk);
    done_exp.push_back(d);
  endtask

  rd_t   m_rd;
  acc_t  m_acc;
  done_t m_done;

  // monitor: compare each DUT strobe against the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        if (rd_exp.size() == 0) fail_now("rd_en unexpected");
        else begin
          m_rd = rd_exp.pop_front();
          check("img_addr", 32'(img_addr), m_rd.img);
          check("w_addr", 32'(w_addr), m_rd.w);
        end
      end
      if (acc_en) begin
        if (acc_exp.size() == 0) fail_now("acc_en unexpected");
        else begin
          m_acc = acc_exp.pop_front();
          check("acc_clr", 32'(acc_clr), 32'(m_acc.clr));
          check("acc_last", 32'(acc_last), 32'(m_acc.last));
          if (m_acc.last) check("out_addr", 32'(out_addr), m_acc.oaddr);
        end
      end
      if (done) begin
        if (done_exp.size() == 0) fail_now("done unexpected");
        else begin
          m_done = done_exp.pop_front();
          check("cfg_err", 32'(cfg_err), 32'(m_done.err));
          check("tap count", 32'(rd_cnt), m_done.taps);
          check("acc events left", 32'(acc_exp.size()), 32'd0);
          check("reads left", 32'(rd_exp.size()), 32'd0);
        end
        rd_cnt = 0;
      end
    end
  end

  // mode: 0 plain, 1 random stall, 2 stall at img_addr 6, 3 start while busy
  task automatic run_pass(input int kk, input int ss, input int st, input int nn,
                          input int mode, output int lat);
    int cyc;
    bit did;
    @(posedge clk); #1;
    kernel_size = 3'(kk); img_size = 5'(ss); stride = 2'(st); number_kernel = 5'(nn);
    start = 1'b1;
    push_pass(kk, ss, st, nn);
    @(posedge clk); #1;
    start = 1'b0;
    kernel_size = 3'($urandom); img_size = 5'($urandom);
    stride = 2'($urandom); number_kernel = 5'($urandom);
    cyc = 1; did = 1'b0; lat = -1;
    while (cyc < 20000) begin
      if (mode == 1) stall = ($urandom_range(0, 3) == 0);
      if (mode == 2 && !did && rd_en && img_addr == 10'd6) begin
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rd_en while stalled", 32'(rd_en), 32'd0);
          check("img_addr held", 32'(img_addr), 32'd6);
          @(posedge clk); #1;
          cyc++;
        end
        stall = 1'b0;
        did = 1'b1;
      end
      start = (mode == 3 && cyc == 10);
      @(negedge clk);
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (lat < 0) fail_now("done timeout");
    else begin
      check("busy at done", 32'(busy), 32'd1);
      @(negedge clk);
      check("done one cycle", 32'(done), 32'd0);
      check("idle after done", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, 32'(rd_en), 32'd0);
    check({tag, " img_addr"}, 32'(img_addr), 32'd0);
    check({tag, " w_addr"}, 32'(w_addr), 32'd0);
    check({tag, " acc_en"}, 32'(acc_en), 32'd0);
    check({tag, " acc_clr"}, 32'(acc_clr), 32'd0);
    check({tag, " acc_last"}, 32'(acc_last), 32'd0);
    check({tag, " out_addr"}, 32'(out_addr), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, " perf_cycles"}, 32'(perf_cycles), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int kk, ss, st, nn;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_pass(3, 5, 1, 1, 0, lat);
`ifdef CONV_SEQ_PERF_EN
    check("perf_cycles", 32'(perf_cycles), 32'd85);
`else
    check("perf_cycles", 32'(perf_cycles), 32'd0);
`endif

    run_pass(3, 5, 2, 2, 0, lat);

    run_pass(6, 5, 1, 1, 0, lat);
    check("illegal K>S done latency", 32'(lat), 32'd2);
    run_pass(3, 5, 0, 1, 0, lat);
    check("stride 0 done latency", 32'(lat), 32'd2);
    run_pass(3, 5, 1, 0, 0, lat);
    check("N 0 done latency", 32'(lat), 32'd2);

    run_pass(3, 5, 1, 1, 2, lat);
    run_pass(3, 5, 1, 1, 3, lat);

    // abort mid-RUN with reset, then a clean pass
    @(posedge clk); #1;
    kernel_size = 3'd3; img_size = 5'd5; stride = 2'd1; number_kernel = 5'd1;
    start = 1'b1;
    push_pass(3, 5, 1, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    rd_exp.delete();
    acc_exp.delete();
    done_exp.delete();
    rd_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      check("done during reset", 32'(done), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    run_pass(3, 5, 1, 1, 0, lat);

    for (int i = 0; i < 12; i++) begin
      kk = $urandom_range(0, 5);
      ss = $urandom_range(1, 10);
      st = $urandom_range(0, 3);
      nn = $urandom_range(0, 3);
      run_pass(kk, ss, st, nn, 1, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Sequences one convolution layer pass from a latched layer configuration: kernel size, image size, stride and kernel count.
- Walks every kernel, output position and kernel tap, and issues read addresses to the image and weight RAMs.
- Drives MAC accumulator control (clear/enable/last) and the output-buffer write address.
- Sits between the layer-config register block and the conv datapath (RAMs plus MAC array); start/done handshake toward the top-level controller.

Parameters:
- IMG_ADDR_W, 10, image RAM address width
- W_ADDR_W, 10, weight RAM address width
- OUT_ADDR_W, 12, output buffer address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin pass; sampled only in IDLE
- kernel_size  in  3  K, kernel edge length
- img_size  in  5  S, square image edge length
- stride  in  2  stride, 1..3
- number_kernel  in  5  N, kernel count
- stall  in  1  downstream not ready; freezes sequencing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  sticky illegal-config flag; cleared on next accepted start
- rd_en  out  1  image/weight RAM read strobe
- img_addr  out  IMG_ADDR_W  image RAM address
- w_addr  out  W_ADDR_W  weight RAM address
- acc_clr  out  1  clear accumulator (first tap of a window, aligned with acc_en)
- acc_en  out  1  accumulate RAM data (rd_en delayed 1 cycle)
- acc_last  out  1  last tap of a window, aligned with acc_en; out_addr valid
- out_addr  out  OUT_ADDR_W  output buffer address of current window
- perf_cycles  out  16  see Optional Feature

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and latched config 0. Reset mid-pass aborts immediately with no done pulse.
- States: IDLE -> CHECK -> CALC -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 latches K, S, stride, N, clears cfg_err, enters CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle): config is illegal if K==0, stride==0, N==0 or K>S. Illegal: set cfg_err and go to FIN (no rd_en ever issued). Legal: rem=S-K, O=1, go to CALC.
- CALC: each cycle, if rem>=stride then rem-=stride and O+=1; else go to RUN. This yields O=floor((S-K)/stride)+1 in floor((S-K)/stride)+1 cycles.
- RUN counters: k (0..N-1, outermost), oy, ox (0..O-1), ky, kx (0..K-1, kx innermost). One tap per non-stalled cycle.
- RUN outputs, combinational from counters, registered onto the outputs:
  - rd_en=1
  - img_addr=(oy*stride+ky)*S + ox*stride + kx
  - w_addr=k*K*K + ky*K + kx
  - out_addr=k*O*O + oy*O + ox
  - Arithmetic is unsigned; results are truncated to port width (the caller guarantees fit).
- Pipeline:
  - acc_en, acc_clr and acc_last are rd_en, first-tap (ky==0 && kx==0) and last-tap (ky==K-1 && kx==K-1) delayed one cycle.
  - out_addr is delayed to align with acc_last.
- stall=1: counters, addresses and pipeline registers hold; rd_en and acc_en are forced to 0 while stalled. When stall is released, the held tap issues with no loss or duplication.
- After the last tap (k=N-1, oy=ox=O-1, ky=kx=K-1) issues, go to DRAIN. DRAIN lasts 1 non-stalled cycle so the final acc_last appears. Then FIN.
- FIN: done=1 for exactly one cycle, busy=1, then IDLE.
- Total RUN taps = N*O*O*K*K.

Optional Feature:
- Macro CONV_SEQ_PERF_EN.
- Defined:
  - perf_cycles clears on accepted start.
  - Increments every cycle in CALC, RUN and DRAIN, including stalled cycles; saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Undefined: perf_cycles is tied to 0 and no counter logic is synthesized.

Test Plan:
- S=5, K=3, stride=1, N=1: CALC 3 cycles, O=3; 81 rd_en pulses. First window img_addr 0,1,2,5,6,7,10,11,12. 9 acc_last pulses with out_addr 0..8. done pulses once.
- S=5, K=3, stride=2, N=2: O=2; second window (ox=1) starts at img_addr 2; kernel 1 w_addr starts at 9, out_addr 4..7; 72 taps total.
- K=6, S=5 (also stride=0 and N=0 in separate runs): cfg_err=1, zero rd_en, done 2 cycles after start.
- stall=1 for 4 cycles mid-window at img_addr 6: img_addr holds 6, rd_en=0; after release, addresses continue 7, 10… with the 81-tap count unchanged.
- rst_n low during RUN: all outputs 0 asynchronously, no done. Then start with the S=5, K=3, stride=1, N=1 config: normal completion.
- start pulsed while busy: ignored, tap count unchanged. With CONV_SEQ_PERF_EN and the S=5, K=3, stride=1, N=1 config without stall: perf_cycles=85 (3 CALC + 81 RUN + 1 DRAIN).
